// File: rtl/mips_pkg.sv
// Shared MIPS constants: data-memory geometry, memory opcodes, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; the pipeline advances every cycle).
package mips_pkg;

  localparam int DM_WORDS = 1024;
  localparam int DM_AW    = 10;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Tnew counts down toward zero and stays there.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t != 2'd0) ? t - 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Data memory: word array with per-byte write enables, combinational read.
// Latency: read is combinational; writes land on the rising edge.
// Backpressure: none; a write is accepted every cycle its byte enables are set.
module dm_ram
  import mips_pkg::*;
#(
  parameter int DM_WORDS = mips_pkg::DM_WORDS,
  parameter int DM_AW    = mips_pkg::DM_AW
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [DM_AW-1:0] Addr,
  input  logic [3:0]       Be,
  input  logic [31:0]      Wdata,
  output logic [31:0]      Rdata
);

  logic [31:0] mem [DM_WORDS];

  // Old contents are visible here in the cycle of a write (read-before-write).
  assign Rdata = mem[Addr];

  // Reset clears every word; otherwise write only the enabled byte lanes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (Be[b]) begin
          mem[Addr][8*b +: 8] <= Wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: load/store decode, byte-lane steering, load extension, MEM/WB register.
// Latency: one cycle from EX/MEM inputs to registered outputs.
// Backpressure: none; one instruction is accepted every cycle.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DM_WORDS = mips_pkg::DM_WORDS,
  parameter int DM_AW    = mips_pkg::DM_AW
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] AluResult_In,
  input  logic [31:0] WriteData_In,
  input  logic [4:0]  WriteReg_In,
  input  logic        RegWrite_In,
  input  logic        MemtoReg_In,
  input  logic        MemWrite_In,
  input  logic        Jal_In,
  input  logic [31:0] Pc_In,
  input  logic [1:0]  Tnew_In,
  input  logic [5:0]  Op_In,
  output logic [31:0] AluResult_Out,
  output logic [31:0] ReadData_Out,
  output logic [31:0] Pc_Out,
  output logic [4:0]  WriteReg_Out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic        Jal_Out,
  output logic [1:0]  Tnew_Out,
  output logic        AdEL_Out,
  output logic        AdES_Out
);

  // Upper address bits are dropped, so addresses alias modulo DM_WORDS*4.
  logic [DM_AW-1:0] word_addr;
  logic [1:0]       byte_off;
  assign word_addr = AluResult_In[DM_AW+1:2];
  assign byte_off  = AluResult_In[1:0];

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] load_val;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        ld_mis;
  logic        st_mis;

  assign half_sel = byte_off[1] ? rword[31:16] : rword[15:0];
  assign byte_sel = rword[8*byte_off +: 8];

  // Store decode: alignment check, byte enables and lane-replicated write data.
  always_comb begin
    be     = 4'b0000;
    wdata  = WriteData_In;
    st_mis = 1'b0;
    unique case (Op_In)
      OP_SW: begin
        st_mis = (byte_off != 2'b00);
        be     = 4'b1111;
      end
      OP_SH: begin
        st_mis = byte_off[0];
        be     = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{WriteData_In[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << byte_off;
        wdata = {4{WriteData_In[7:0]}};
      end
      default: ;
    endcase
    if (!MemWrite_In || st_mis) begin
      be = 4'b0000;
    end
  end

  // Load decode: alignment check and sign/zero extension of the selected lane.
  always_comb begin
    ld_mis   = 1'b0;
    load_val = '0;
    unique case (Op_In)
      OP_LW: begin
        ld_mis   = (byte_off != 2'b00);
        load_val = rword;
      end
      OP_LH: begin
        ld_mis   = byte_off[0];
        load_val = {{16{half_sel[15]}}, half_sel};
      end
      OP_LHU: begin
        ld_mis   = byte_off[0];
        load_val = {16'h0000, half_sel};
      end
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: ;
    endcase
    if (ld_mis) begin
      load_val = '0;
    end
  end

  dm_ram #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm_ram (
    .Clk   (Clk),
    .Reset (Reset),
    .Addr  (word_addr),
    .Be    (be),
    .Wdata (wdata),
    .Rdata (rword)
  );

  // MEM/WB pipeline register; a faulting load never writes the register file.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      AluResult_Out <= '0;
      ReadData_Out  <= '0;
      Pc_Out        <= '0;
      WriteReg_Out  <= '0;
      RegWrite_Out  <= 1'b0;
      MemtoReg_Out  <= 1'b0;
      Jal_Out       <= 1'b0;
      Tnew_Out      <= '0;
      AdEL_Out      <= 1'b0;
      AdES_Out      <= 1'b0;
    end else begin
      AluResult_Out <= AluResult_In;
      ReadData_Out  <= load_val;
      Pc_Out        <= Pc_In;
      WriteReg_Out  <= WriteReg_In;
      RegWrite_Out  <= RegWrite_In && !ld_mis;
      MemtoReg_Out  <= MemtoReg_In;
      Jal_Out       <= Jal_In;
      Tnew_Out      <= tnew_dec(Tnew_In);
      AdEL_Out      <= ld_mis;
      AdES_Out      <= st_mis;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random load/store traffic.
// Latency: expects every output one clock after the inputs are presented.
// Backpressure: none; one instruction is driven per clock.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int NB = DM_WORDS * 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] AluResult_In, WriteData_In, Pc_In;
  logic [4:0]  WriteReg_In;
  logic        RegWrite_In, MemtoReg_In, MemWrite_In, Jal_In;
  logic [1:0]  Tnew_In;
  logic [5:0]  Op_In;
  logic [31:0] AluResult_Out, ReadData_Out, Pc_Out;
  logic [4:0]  WriteReg_Out;
  logic        RegWrite_Out, MemtoReg_Out, Jal_Out, AdEL_Out, AdES_Out;
  logic [1:0]  Tnew_Out;

  mem_stage dut (
    .Clk(Clk), .Reset(Reset),
    .AluResult_In(AluResult_In), .WriteData_In(WriteData_In), .WriteReg_In(WriteReg_In),
    .RegWrite_In(RegWrite_In), .MemtoReg_In(MemtoReg_In), .MemWrite_In(MemWrite_In),
    .Jal_In(Jal_In), .Pc_In(Pc_In), .Tnew_In(Tnew_In), .Op_In(Op_In),
    .AluResult_Out(AluResult_Out), .ReadData_Out(ReadData_Out), .Pc_Out(Pc_Out),
    .WriteReg_Out(WriteReg_Out), .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .Jal_Out(Jal_Out), .Tnew_Out(Tnew_Out), .AdEL_Out(AdEL_Out), .AdES_Out(AdES_Out)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Byte-addressed reference memory.
  logic [7:0] bmem [NB];

  // Expected MEM/WB contents.
  logic [31:0] e_alu, e_rd, e_pc;
  logic [4:0]  e_wr;
  logic        e_rw, e_m2r, e_jal, e_adel, e_ades;
  logic [1:0]  e_tnew;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) bmem[i] = 8'h00;
    e_alu = '0; e_rd = '0; e_pc = '0; e_wr = '0; e_rw = 0; e_m2r = 0;
    e_jal = 0; e_tnew = '0; e_adel = 0; e_ades = 0;
  endtask

  // Compute expected outputs from the current inputs, then apply any store.
  task automatic model();
    int a;
    logic [15:0] h;
    a = AluResult_In % NB;
    h = {bmem[(a + 1) % NB], bmem[a]};
    e_rd = 0; e_adel = 0; e_ades = 0;
    case (Op_In)
      OP_LW:  if (a % 4 != 0) e_adel = 1;
              else e_rd = {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
      OP_LH:  if (a % 2 != 0) e_adel = 1; else e_rd = {{16{h[15]}}, h};
      OP_LHU: if (a % 2 != 0) e_adel = 1; else e_rd = {16'h0, h};
      OP_LB:  e_rd = {{24{bmem[a][7]}}, bmem[a]};
      OP_LBU: e_rd = {24'h0, bmem[a]};
      OP_SW:  e_ades = (a % 4 != 0);
      OP_SH:  e_ades = (a % 2 != 0);
      default: ;
    endcase
    e_alu = AluResult_In; e_pc = Pc_In; e_wr = WriteReg_In;
    e_rw = RegWrite_In && !e_adel; e_m2r = MemtoReg_In; e_jal = Jal_In;
    e_tnew = (Tnew_In == 0) ? 2'd0 : Tnew_In - 1;
    if (MemWrite_In && !e_ades) begin
      case (Op_In)
        OP_SW: for (int k = 0; k < 4; k++) bmem[a+k] = WriteData_In[8*k +: 8];
        OP_SH: for (int k = 0; k < 2; k++) bmem[a+k] = WriteData_In[8*k +: 8];
        OP_SB: bmem[a] = WriteData_In[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".alu"}, AluResult_Out, e_alu);
    check({tag, ".rd"},  ReadData_Out,  e_rd);
    check({tag, ".pc"},  Pc_Out,        e_pc);
    check({tag, ".ctl"},
          {19'h0, WriteReg_Out, RegWrite_Out, MemtoReg_Out, Jal_Out, Tnew_Out, AdEL_Out, AdES_Out},
          {19'h0, e_wr, e_rw, e_m2r, e_jal, e_tnew, e_adel, e_ades});
  endtask

  // Present one instruction, clock it, and check all outputs #1 after the edge.
  task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rw, input logic [1:0] tnew);
    Op_In = op; AluResult_In = addr; WriteData_In = wd; RegWrite_In = rw; Tnew_In = tnew;
    MemWrite_In = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    MemtoReg_In = 1'($urandom); Jal_In = 1'($urandom);
    WriteReg_In = 5'($urandom); Pc_In = $urandom;
    model();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'h00, 6'h0F};
    Reset = 1'b0;
    Op_In = 6'h00; AluResult_In = '0; WriteData_In = '0; WriteReg_In = '0; Pc_In = '0;
    RegWrite_In = 0; MemtoReg_In = 0; MemWrite_In = 0; Jal_In = 0; Tnew_In = '0;
    clear_model();
    #12;
    compare_all("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    issue("sw10", OP_SW, 32'h10, 32'h12345678, 0, 2'd0);
    issue("lw10", OP_LW, 32'h10, 32'h0, 1, 2'd1);
    check("lw10.const", ReadData_Out, 32'h12345678);
    issue("sb13", OP_SB, 32'h13, 32'h000000AB, 0, 2'd0);
    issue("lb13", OP_LB, 32'h13, 32'h0, 1, 2'd1);
    check("lb13.const", ReadData_Out, 32'hFFFFFFAB);
    issue("lbu13", OP_LBU, 32'h13, 32'h0, 1, 2'd1);
    check("lbu13.const", ReadData_Out, 32'h000000AB);
    issue("lw10b", OP_LW, 32'h10, 32'h0, 1, 2'd1);
    check("lw10b.const", ReadData_Out, 32'hAB345678);
    issue("sh22", OP_SH, 32'h22, 32'h00008001, 0, 2'd0);
    issue("lh22", OP_LH, 32'h22, 32'h0, 1, 2'd1);
    check("lh22.const", ReadData_Out, 32'hFFFF8001);
    issue("lhu22", OP_LHU, 32'h22, 32'h0, 1, 2'd1);
    check("lhu22.const", ReadData_Out, 32'h00008001);
    issue("sh21", OP_SH, 32'h21, 32'h00005555, 0, 2'd0);
    check("sh21.ades", {31'h0, AdES_Out}, 32'd1);
    issue("lw20", OP_LW, 32'h20, 32'h0, 1, 2'd1);
    check("lw20.const", ReadData_Out, 32'h80010000);
    check("lw20.ades", {31'h0, AdES_Out}, 32'd0);
    issue("lw0e", OP_LW, 32'h0E, 32'h0, 1, 2'd1);
    check("lw0e.flags", {29'h0, AdEL_Out, RegWrite_Out, 1'b0}, {29'h0, 1'b1, 1'b0, 1'b0});
    issue("lw10c", OP_LW, 32'h10, 32'h0, 1, 2'd1);
    check("lw10c.adel", {31'h0, AdEL_Out}, 32'd0);
    issue("tnew2", 6'h00, 32'h44, 32'h0, 1, 2'd2);
    check("tnew2.const", {30'h0, Tnew_Out}, 32'd1);
    issue("tnew0", 6'h00, 32'h48, 32'h0, 1, 2'd0);
    check("tnew0.const", {30'h0, Tnew_Out}, 32'd0);
    issue("alias", OP_LW, 32'h1010, 32'h0, 1, 2'd3);
    check("alias.const", ReadData_Out, 32'hAB345678);

    // Asynchronous reset mid-stream with a store pending.
    Op_In = OP_SW; AluResult_In = 32'h10; WriteData_In = 32'hDEADBEEF; MemWrite_In = 1;
    RegWrite_In = 1; Pc_In = 32'h400; Tnew_In = 2'd2;
    #3 Reset = 1'b0;
    clear_model();
    #1;
    compare_all("rst_async");
    @(posedge Clk);
    #1;
    compare_all("rst_hold");
    Op_In = 6'h00; MemWrite_In = 0;
    @(negedge Clk);
    Reset = 1'b1;
    issue("rst_lw10", OP_LW, 32'h10, 32'h0, 1, 2'd1);
    check("rst_lw10.const", ReadData_Out, 32'h0);

    // Random traffic against the byte-level model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 3) << 12) | $urandom_range(0, 63);
      issue("rand", ops[$urandom_range(0, 9)], addr, $urandom, 1'($urandom),
            2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
